// File: rtl/rah_version_check_mc.sv
// RAH version checker: pops one request, decodes its opcode and streams one or
// more response packets (version, per-app capability table, ping echo, error).
module rah_version_check_mc #(
    parameter int                    PACKET_WIDTH = 48,
    parameter int                    NUM_APPS     = 4,
    parameter logic [7:0]            VER_MAJOR    = 8'd1,
    parameter logic [7:0]            VER_MINOR    = 8'd2,
    parameter logic [7:0]            VER_PATCH    = 8'd0,
    parameter logic [NUM_APPS*8-1:0] APP_VERSIONS = {NUM_APPS{8'h01}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKET_WIDTH-1:0] in_data,
    input  logic                    q_empty,
    input  logic                    out_full,
    output logic                    request_data,
    output logic                    w_en,
    output logic [PACKET_WIDTH-1:0] out_data,
    output logic                    busy,
    output logic [15:0]             req_count
);

    localparam logic [7:0] OP_GET_VERSION = 8'h01;
    localparam logic [7:0] OP_GET_CAPS    = 8'h02;
    localparam logic [7:0] OP_PING        = 8'h03;
    localparam logic [7:0] NUM_APPS_B     = 8'(NUM_APPS);
    localparam logic [8:0] NUM_APPS_W     = 9'(NUM_APPS);
    localparam logic [8:0] CAPS_PACKETS   = 9'(NUM_APPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DECODE,
        ST_SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [47:0]             req_q, req_d;
    logic [15:0]             req_count_q, req_count_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [8:0]              idx_q, idx_d;
    logic [PACKET_WIDTH-1:0] out_data_q, out_data_d;
    logic                    busy_q, busy_d;

    logic [7:0]              app_ver [NUM_APPS];

    for (genvar gi = 0; gi < NUM_APPS; gi++) begin : g_app_ver
        assign app_ver[gi] = APP_VERSIONS[gi*8 +: 8];
    end

    logic [7:0]              opcode;
    logic [7:0]              app_id;
    logic                    app_ok;
    logic [8:0]              pkt_sel;
    logic [8:0]              ver_idx;
    logic [7:0]              cap_ver;
    logic [47:0]             pkt_core;
    logic [PACKET_WIDTH-1:0] next_pkt;

    assign opcode  = req_q[7:0];
    assign app_id  = req_q[15:8];
    assign app_ok  = ({1'b0, app_id} < NUM_APPS_W);
    // Packet 0 is built while decoding; during SEND we precompute the one after the current.
    assign pkt_sel = (state_q == ST_SEND) ? (idx_q + 9'd1) : 9'd0;
    assign ver_idx = pkt_sel - 9'd1;

    always_comb begin
        cap_ver = 8'h00;
        for (int k = 0; k < NUM_APPS; k++) begin
            if (ver_idx == 9'(k)) begin
                cap_ver = app_ver[k];
            end
        end
    end

    always_comb begin
        pkt_core = 48'h0;
        case (opcode)
            OP_GET_VERSION: begin
                if (app_ok) begin
                    pkt_core = {NUM_APPS_B, VER_PATCH, VER_MINOR, VER_MAJOR, app_id, 8'h81};
                end else begin
                    pkt_core = {16'h0, 8'h01, opcode, app_id, 8'hFF};
                end
            end
            OP_GET_CAPS: begin
                if (pkt_sel == 9'd0) begin
                    pkt_core = {24'h0, NUM_APPS_B, app_id, 8'h82};
                end else begin
                    pkt_core = {16'h0, cap_ver, ver_idx[7:0], app_id, 8'h82};
                end
            end
            OP_PING: begin
                if (app_ok) begin
                    pkt_core = {req_q[47:16], app_id, 8'h83};
                end else begin
                    pkt_core = {16'h0, 8'h01, opcode, app_id, 8'hFF};
                end
            end
            default: begin
                pkt_core = {16'h0, 8'h00, opcode, app_id, 8'hFF};
            end
        endcase
    end

    always_comb begin
        next_pkt        = '0;
        next_pkt[47:0]  = pkt_core;
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        req_count_d = req_count_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_d = in_data[47:0];
                if (req_count_q != 16'hFFFF) begin
                    req_count_d = req_count_q + 16'd1;
                end
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                cnt_d      = (opcode == OP_GET_CAPS) ? CAPS_PACKETS : 9'd1;
                idx_d      = 9'd0;
                out_data_d = next_pkt;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                // A stalled write leaves out_data untouched so the FIFO sees a stable word.
                if (!out_full) begin
                    if (cnt_q == 9'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d      = cnt_q - 9'd1;
                        idx_d      = idx_q + 9'd1;
                        out_data_d = next_pkt;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            req_count_q <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_count_q <= req_count_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    // Strobes follow the live FIFO flags so a pop or write never acts on stale status.
    assign request_data = (state_q == ST_IDLE) && !q_empty && !rst;
    assign w_en         = (state_q == ST_SEND) && !out_full && !rst;
    assign out_data     = out_data_q;
    assign busy         = busy_q;
    assign req_count    = req_count_q;

endmodule

// File: tb/tb_rah_version_check_mc.sv
// Directed bench for rah_version_check_mc with a small FIFO model on each side.
module tb_rah_version_check_mc;

    localparam int PW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] in_data;
    logic          q_empty;
    logic          out_full;
    logic          request_data;
    logic          w_en;
    logic [PW-1:0] out_data;
    logic          busy;
    logic [15:0]   req_count;

    int checks = 0;
    int errors = 0;
    int cnum   = 0;
    int pop_cyc = 0;

    logic [47:0] fifo[$];
    logic [47:0] got[$];
    int          wr_cyc[$];

    logic        s_req, s_wen, s_busy, s_qe;
    logic [47:0] s_out;
    logic [15:0] s_cnt;
    logic [47:0] w;

    logic [31:0] caps_exp [5] = '{32'h00040082, 32'h01000082, 32'h02010082,
                                  32'h03020082, 32'h04030082};

    always #5 clk = ~clk;

    rah_version_check_mc #(
        .PACKET_WIDTH(PW),
        .NUM_APPS    (4),
        .APP_VERSIONS(32'h04030201)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .q_empty     (q_empty),
        .out_full    (out_full),
        .request_data(request_data),
        .w_en        (w_en),
        .out_data    (out_data),
        .busy        (busy),
        .req_count   (req_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] gw(input int i);
        return (i < got.size()) ? got[i] : '1;
    endfunction

    function automatic int wc(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -100;
    endfunction

    task automatic push(input logic [47:0] d);
        fifo.push_back(d);
        q_empty = 1'b0;
    endtask

    // One clock: sample at negedge, then emulate the FIFO pop just after posedge.
    task automatic cyc();
        logic pop;
        @(negedge clk);
        cnum++;
        s_req  = request_data;
        s_wen  = w_en;
        s_out  = out_data;
        s_busy = busy;
        s_cnt  = req_count;
        s_qe   = q_empty;
        if (s_wen) begin
            got.push_back(s_out);
            wr_cyc.push_back(cnum);
            $display("cycle %0d: write out_data=%012h", cnum, s_out);
        end
        pop = s_req;
        if (s_req) begin
            pop_cyc = cnum;
            $display("cycle %0d: pop request", cnum);
            chk("pop_when_empty", 64'(s_qe), 64'd0);
        end
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) begin
            in_data = fifo.pop_front();
        end
        q_empty = (fifo.size() == 0);
    endtask

    task automatic run_until(input int n, input int max, input string tag);
        for (int i = 0; i < max && got.size() < n; i++) begin
            cyc();
        end
        chk(tag, 64'(got.size()), 64'(n));
    endtask

    task automatic clear_capture();
        got.delete();
        wr_cyc.delete();
    endtask

    initial begin
        rst      = 1'b1;
        out_full = 1'b0;
        in_data  = '0;
        q_empty  = 1'b1;
        push(48'h000000000001);

        // Reset held with a non-empty queue
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_req",  64'(s_req),  64'd0);
            chk("rst_wen",  64'(s_wen),  64'd0);
            chk("rst_out",  64'(s_out),  64'd0);
            chk("rst_cnt",  64'(s_cnt),  64'd0);
            chk("rst_busy", 64'(s_busy), 64'd0);
        end
        rst = 1'b0;
        cyc();
        chk("first_req", 64'(s_req), 64'd1);

        // GET_VERSION with default versions
        clear_capture();
        run_until(1, 10, "ver_count");
        chk("ver_data", 64'(gw(0)), 64'h040002010081);
        chk("ver_latency", 64'(wc(0) - pop_cyc), 64'd3);
        for (int i = 0; i < 4; i++) cyc();
        chk("ver_single",    64'(got.size()), 64'd1);
        chk("ver_req_count", 64'(s_cnt),      64'd1);
        chk("ver_idle",      64'(s_busy),     64'd0);

        // GET_CAPS burst
        clear_capture();
        push(48'h000000000002);
        run_until(5, 20, "caps_count");
        for (int i = 0; i < 5; i++) begin
            w = gw(i);
            chk("caps_pkt", 64'(w[31:0]), 64'(caps_exp[i]));
            chk("caps_consec", 64'(wc(i) - wc(0)), 64'(i));
        end
        for (int i = 0; i < 3; i++) cyc();
        chk("caps_total", 64'(got.size()), 64'd5);

        // Back-pressure in the middle of a GET_CAPS burst
        clear_capture();
        push(48'h000000000202);
        run_until(2, 20, "bp_first2");
        out_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("bp_wen",  64'(s_wen),       64'd0);
            chk("bp_hold", 64'(s_out[31:0]), 64'h02010282);
            chk("bp_busy", 64'(s_busy),      64'd1);
        end
        out_full = 1'b0;
        run_until(5, 20, "bp_count");
        for (int i = 0; i < 4; i++) cyc();
        chk("bp_total", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            w = gw(i);
            chk("bp_pkt", 64'(w[31:0]), 64'(caps_exp[i] | 32'h00000200));
        end

        // Error paths, ping echo and back-to-back throughput
        clear_capture();
        push(48'h00000000007E);
        push(48'h000000000501);
        push(48'hABCD12340103);
        run_until(3, 30, "err_count");
        w = gw(0);
        chk("err_op_code",   64'(w[7:0]),   64'hFF);
        chk("err_op_field",  64'(w[23:16]), 64'h7E);
        w = gw(1);
        chk("err_app_code",  64'(w[7:0]),   64'hFF);
        chk("err_app_id",    64'(w[15:8]),  64'h05);
        chk("err_app_field", 64'(w[31:24]), 64'h01);
        chk("ping_data",     64'(gw(2)),    64'hABCD12340183);
        chk("throughput",    64'(wc(1) - wc(0)), 64'd4);
        for (int i = 0; i < 3; i++) cyc();
        chk("err_total",  64'(got.size()), 64'd3);
        chk("req_count6", 64'(s_cnt),      64'd6);

        // Reset during the third GET_CAPS packet
        clear_capture();
        push(48'h000000000002);
        push(48'h000000000301);
        run_until(2, 20, "rst_mid_first2");
        rst = 1'b1;
        cyc();
        chk("rst_mid_wen", 64'(s_wen), 64'd0);
        rst = 1'b0;
        cyc();
        chk("rst_mid_out",  64'(s_out),  64'd0);
        chk("rst_mid_cnt",  64'(s_cnt),  64'd0);
        chk("rst_mid_busy", 64'(s_busy), 64'd0);
        chk("rst_mid_req",  64'(s_req),  64'd1);
        chk("rst_mid_drop", 64'(got.size()), 64'd2);
        clear_capture();
        run_until(1, 10, "post_rst_count");
        chk("post_rst_data", 64'(gw(0)), 64'h040002010381);
        for (int i = 0; i < 4; i++) cyc();
        chk("post_rst_single", 64'(got.size()), 64'd1);
        chk("post_rst_cnt",    64'(s_cnt),      64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
